// File: rtl/clock_controller.sv
// CPU clock generator for the TD4 mother board: slow/fast free-running rates,
// a debounced single-step button and a halt mode, all from the board clock.
module clock_controller #(
  parameter int HALF_SLOW = 25_000_000,
  parameter int HALF_FAST = 2_500_000,
  parameter int DEBOUNCE  = 1_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] mode,
  input  logic       step_button,
  output logic       cpu_clock,
  output logic       cpu_tick,
  output logic [7:0] steps
);

  localparam int MAX_HALF = (HALF_SLOW > HALF_FAST) ? HALF_SLOW : HALF_FAST;
  localparam int MAX_PAR  = (MAX_HALF > DEBOUNCE) ? MAX_HALF : DEBOUNCE;
  localparam int CW       = $clog2(MAX_PAR);

  localparam logic [CW-1:0] SLOW_M1 = CW'(HALF_SLOW - 1);
  localparam logic [CW-1:0] FAST_M1 = CW'(HALF_FAST - 1);
  localparam logic [CW-1:0] DB_M1   = CW'(DEBOUNCE - 1);

  typedef enum logic { ST_LOW, ST_HIGH } state_t;
  typedef enum logic { SRC_AUTO, SRC_MANUAL } src_t;

  logic [1:0]    mode_meta_q, mode_meta_d;
  logic [1:0]    mode_s_q, mode_s_d;
  logic [1:0]    mode_prev_q, mode_prev_d;
  logic          btn_meta_q, btn_meta_d;
  logic          btn_s_q, btn_s_d;
  logic          btn_db_q, btn_db_d;
  logic          btn_db_prev_q, btn_db_prev_d;
  logic [CW-1:0] db_cnt_q, db_cnt_d;
  state_t        state_q, state_d;
  src_t          src_q, src_d;
  logic [CW-1:0] ph_cnt_q, ph_cnt_d;
  logic [CW-1:0] half_m1_q, half_m1_d;
  logic          tick_q, tick_d;
  logic [7:0]    steps_q, steps_d;

  logic          press;
  logic          mode_changed;
  logic          rise;
  logic [CW-1:0] cur_m1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      mode_meta_q   <= 2'b00;
      mode_s_q      <= 2'b00;
      mode_prev_q   <= 2'b00;
      btn_meta_q    <= 1'b0;
      btn_s_q       <= 1'b0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      db_cnt_q      <= '0;
      state_q       <= ST_LOW;
      src_q         <= SRC_AUTO;
      ph_cnt_q      <= '0;
      half_m1_q     <= '0;
      tick_q        <= 1'b0;
      steps_q       <= 8'd0;
    end else begin
      mode_meta_q   <= mode_meta_d;
      mode_s_q      <= mode_s_d;
      mode_prev_q   <= mode_prev_d;
      btn_meta_q    <= btn_meta_d;
      btn_s_q       <= btn_s_d;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_prev_d;
      db_cnt_q      <= db_cnt_d;
      state_q       <= state_d;
      src_q         <= src_d;
      ph_cnt_q      <= ph_cnt_d;
      half_m1_q     <= half_m1_d;
      tick_q        <= tick_d;
      steps_q       <= steps_d;
    end
  end

  // Debouncer: btn_db only follows btn_s after DEBOUNCE consecutive differing cycles.
  always_comb begin
    mode_meta_d   = mode;
    mode_s_d      = mode_meta_q;
    mode_prev_d   = mode_s_q;
    btn_meta_d    = step_button;
    btn_s_d       = btn_meta_q;
    btn_db_prev_d = btn_db_q;
    btn_db_d      = btn_db_q;
    db_cnt_d      = '0;
    if (btn_s_q != btn_db_q) begin
      if (db_cnt_q == DB_M1) begin
        btn_db_d = btn_s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign press        = btn_db_q & ~btn_db_prev_q;
  assign mode_changed = (mode_s_q != mode_prev_q);
  assign cur_m1       = mode_s_q[0] ? FAST_M1 : SLOW_M1;

  // Mode is only acted on in LOW, so a switch can never shorten a phase in flight.
  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    ph_cnt_d  = ph_cnt_q;
    half_m1_d = half_m1_q;
    rise      = 1'b0;
    if (state_q == ST_LOW) begin
      if (mode_changed) begin
        ph_cnt_d = '0;
      end else begin
        case (mode_s_q)
          2'b00, 2'b01: begin
            if (ph_cnt_q == cur_m1) begin
              state_d   = ST_HIGH;
              src_d     = SRC_AUTO;
              half_m1_d = cur_m1;
              ph_cnt_d  = '0;
              rise      = 1'b1;
            end else begin
              ph_cnt_d = ph_cnt_q + 1'b1;
            end
          end
          2'b10: begin
            ph_cnt_d = '0;
            if (press) begin
              state_d = ST_HIGH;
              src_d   = SRC_MANUAL;
              rise    = 1'b1;
            end
          end
          default: ph_cnt_d = '0;
        endcase
      end
    end else begin
      if (src_q == SRC_AUTO) begin
        if (ph_cnt_q == half_m1_q) begin
          state_d  = ST_LOW;
          ph_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + 1'b1;
        end
      end else begin
        ph_cnt_d = '0;
        if (!btn_db_q) begin
          state_d = ST_LOW;
        end
      end
    end
  end

  always_comb begin
    tick_d  = rise;
    steps_d = rise ? (steps_q + 8'd1) : steps_q;
  end

  assign cpu_clock = (state_q == ST_HIGH);
  assign cpu_tick  = tick_q;
  assign steps     = steps_q;

endmodule
